// File: rtl/present_ti_compress_pkg.sv
// Shared constants, pipeline stage state types and the cf_in bit-index mapping
// for the threshold-implementation PRESENT S-box share compressor.
package present_ti_compress_pkg;

  localparam int NUM_COORD = 4;
  localparam int NUM_SHARE = 3;
  localparam int NUM_CF    = 36;
  localparam int RND_W     = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  typedef struct packed {
    stage_state_t s1;
    stage_state_t s2;
  } pipe_state_t;

  // Term of coordinate m produced for shares i, j (both 1-based) inside cf_in.
  function automatic logic [5:0] cf_index(input int m, input int i, input int j);
    return 6'(9 * m + 3 * (i - 1) + (j - 1));
  endfunction

endpackage

// File: rtl/present_ti_compress_bit.sv
// One S-box output coordinate: folds 9 component-function terms into 3 shares,
// optionally re-masked with two fresh random bits whose XOR cancels across shares.
module ti_compress_bit
  import present_ti_compress_pkg::*;
#(
  parameter int REFRESH = 1
) (
  input  logic [8:0] terms,
  input  logic [1:0] rnd,
  output logic [2:0] sh
);

  logic [NUM_SHARE-1:0] raw;

  for (genvar s = 0; s < NUM_SHARE; s++) begin : g_raw
    assign raw[s] = ^terms[3*s +: 3];
  end

  if (REFRESH != 0) begin : g_refresh
    assign sh = raw ^ {rnd[0] ^ rnd[1], rnd[1], rnd[0]};
  end else begin : g_bypass
    logic unused_rnd;
    assign unused_rnd = ^rnd;
    assign sh         = raw;
  end

endmodule

// File: rtl/present_ti_compress.sv
// Two-stage valid/ready pipeline: stage 1 registers the raw TI terms as a glitch
// barrier, stage 2 registers the compressed (and refreshed) output shares.
module present_ti_compress
  import present_ti_compress_pkg::*;
#(
  parameter int REFRESH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CF-1:0]   cf_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RND_W-1:0]    rnd,
  output logic [NUM_COORD-1:0] sh1,
  output logic [NUM_COORD-1:0] sh2,
  output logic [NUM_COORD-1:0] sh3,
  output logic                out_valid,
  input  logic                out_ready
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; ready never looks at the same-side valid.
  stage_state_t s1_state_q, s1_state_d;
  stage_state_t s2_state_q, s2_state_d;
  pipe_state_t  dbg_state;

  logic [NUM_CF-1:0]    cf_q, cf_d;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  logic [NUM_COORD-1:0] sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [1:0]           occ_q, occ_d;

  logic s1_valid, s2_valid, s1_adv, in_fire, out_fire;
  logic [NUM_COORD-1:0] c_sh1, c_sh2, c_sh3;

  // State register process.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state_q <= ST_EMPTY;
      s2_state_q <= ST_EMPTY;
      cf_q       <= '0;
      rnd_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      sh3_q      <= '0;
      occ_q      <= '0;
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
      cf_q       <= cf_d;
      rnd_q      <= rnd_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      sh3_q      <= sh3_d;
      occ_q      <= occ_d;
    end
  end

  // Output / handshake process: everything here derives from registered state
  // plus the opposite-side handshake input.
  always_comb begin
    s1_valid  = (s1_state_q == ST_FULL);
    s2_valid  = (s2_state_q == ST_FULL);
    s1_adv    = s1_valid & (!s2_valid | out_ready);
    in_ready  = !s1_valid | !s2_valid | out_ready;
    in_fire   = in_valid & in_ready;
    out_fire  = s2_valid & out_ready;
    out_valid = s2_valid;
    sh1       = sh1_q;
    sh2       = sh2_q;
    sh3       = sh3_q;
    dbg_state = '{s1: s1_state_q, s2: s2_state_q};
  end

  // Next-state process.
  always_comb begin
    s1_state_d = s1_state_q;
    s2_state_d = s2_state_q;
    case (s1_state_q)
      ST_EMPTY: if (in_fire) s1_state_d = ST_FULL;
      ST_FULL:  if (s1_adv && !in_fire) s1_state_d = ST_EMPTY;
      default:  s1_state_d = ST_EMPTY;
    endcase
    case (s2_state_q)
      ST_EMPTY: if (s1_adv) s2_state_d = ST_FULL;
      ST_FULL:  if (out_fire && !s1_adv) s2_state_d = ST_EMPTY;
      default:  s2_state_d = ST_EMPTY;
    endcase
  end

  for (genvar m = 0; m < NUM_COORD; m++) begin : g_coord
    logic [8:0] terms;
    logic [2:0] sh;
    for (genvar i = 1; i <= NUM_SHARE; i++) begin : g_i
      for (genvar j = 1; j <= NUM_SHARE; j++) begin : g_j
        assign terms[3*(i-1) + (j-1)] = cf_q[cf_index(m, i, j)];
      end
    end
    ti_compress_bit #(.REFRESH(REFRESH)) u_bit (
      .terms (terms),
      .rnd   (rnd_q[2*m +: 2]),
      .sh    (sh)
    );
    assign c_sh1[m] = sh[0];
    assign c_sh2[m] = sh[1];
    assign c_sh3[m] = sh[2];
  end

  // Data registers move only on their stage's load enable, so idle cycles never
  // toggle share logic.
  always_comb begin
    cf_d  = cf_q;
    rnd_d = rnd_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    sh3_d = sh3_q;
    if (in_fire) begin
      cf_d  = cf_in;
      rnd_d = rnd;
    end
    if (s1_adv) begin
      sh1_d = c_sh1;
      sh2_d = c_sh2;
      sh3_d = c_sh3;
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  occ_consistent: assert property (@(posedge clk) disable iff (rst)
    (occ_q != 2'd3) &&
    (occ_q == ({1'b0, dbg_state.s1 == ST_FULL} + {1'b0, dbg_state.s2 == ST_FULL})));

endmodule

// File: tb/tb_present_ti_compress.sv
// Directed and randomized checks of the TI share compressor against a
// PRESENT S-box reference and a per-share behavioural model.
module tb_present_ti_compress;

  logic        clk;
  logic        rst;
  logic [35:0] cf_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  rnd;
  logic [3:0]  sh1, sh2, sh3;
  logic        out_valid;
  logic        out_ready;

  present_ti_compress #(.REFRESH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cf_in     (cf_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd       (rnd),
    .sh1       (sh1),
    .sh2       (sh2),
    .sh3       (sh3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [3:0]  sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0]  cur_xor;
  int          n_pass, n_total, n_in, n_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Shares from the spec's rules: raw share s = XOR of its 3 terms, then the
  // refresh pattern (r0, r1, r0^r1). Returns {xor_of_all_terms, sh3, sh2, sh1}.
  function automatic logic [15:0] model(input logic [35:0] cf, input logic [7:0] r);
    logic [3:0] e1, e2, e3, ex;
    for (int m = 0; m < 4; m++) begin
      logic [2:0] raw;
      for (int s = 0; s < 3; s++)
        raw[s] = cf[9*m + 3*s] ^ cf[9*m + 3*s + 1] ^ cf[9*m + 3*s + 2];
      e1[m] = raw[0] ^ r[2*m];
      e2[m] = raw[1] ^ r[2*m + 1];
      e3[m] = raw[2] ^ r[2*m] ^ r[2*m + 1];
      ex[m] = ^raw;
    end
    return {ex, e3, e2, e1};
  endfunction

  // Random masked terms whose per-coordinate XOR is S(x).
  function automatic logic [35:0] gen_cf(input logic [3:0] x);
    logic [35:0] cf;
    logic [3:0]  y;
    y = sbox_tab[x];
    cf = '0;
    for (int m = 0; m < 4; m++) begin
      logic [7:0] t;
      t = 8'($urandom_range(0, 255));
      cf[9*m +: 9] = {(^t) ^ y[m], t};
    end
    return cf;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_random_input();
    logic [3:0] x;
    x       = 4'($urandom_range(0, 15));
    cf_in   = gen_cf(x);
    rnd     = 8'($urandom_range(0, 255));
    cur_xor = sbox_tab[x];
  endtask

  task automatic set_directed_input(input logic [35:0] cf, input logic [7:0] r);
    logic [15:0] mres;
    cf_in   = cf;
    rnd     = r;
    mres    = model(cf, r);
    cur_xor = mres[15:12];
  endtask

  // One clock: observe transfers mid-cycle, then step past the rising edge.
  task automatic cycle();
    logic [15:0] e, mres;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {20'h0, sh3, sh2, sh1}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sh1", {28'h0, sh1}, {28'h0, e[3:0]});
        check("sh2", {28'h0, sh2}, {28'h0, e[7:4]});
        check("sh3", {28'h0, sh3}, {28'h0, e[11:8]});
        check("share_xor_sbox", {28'h0, sh1 ^ sh2 ^ sh3}, {28'h0, e[15:12]});
      end
    end
    if (!rst && in_valid && in_ready) begin
      n_in++;
      mres = model(cf_in, rnd);
      exp_q.push_back({cur_xor, mres[11:0]});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    int a_in, a_out, seen;
    logic [11:0] snap;
    logic        snap_ok;
    n_pass = 0; n_total = 0; n_in = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cf_in = '0; rnd = '0; cur_xor = '0;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_shares", {20'h0, sh3, sh2, sh1}, 32'h0);
    check("rst_occ", {30'h0, dut.occ_q}, 32'h0);

    // All-zero terms with rnd=FF: shares are pure mask (1,1,0 per bit).
    out_ready = 1'b1; in_valid = 1'b1;
    set_directed_input(36'h0, 8'hFF);
    cycle();
    in_valid = 1'b0;
    check("zero_lat1_valid", {31'h0, out_valid}, 32'h0);
    cycle();
    check("zero_lat2_valid", {31'h0, out_valid}, 32'h1);
    check("zero_sh1", {28'h0, sh1}, 32'hF);
    check("zero_sh2", {28'h0, sh2}, 32'hF);
    check("zero_sh3", {28'h0, sh3}, 32'h0);
    check("zero_xor", {28'h0, sh1 ^ sh2 ^ sh3}, 32'h0);
    cycle();
    check("zero_drained", {31'h0, out_valid}, 32'h0);

    // Single term bit 0 without mask lands only in sh1 coordinate 0.
    in_valid = 1'b1;
    set_directed_input(36'h1, 8'h00);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("bit0_valid", {31'h0, out_valid}, 32'h1);
    check("bit0_sh1", {28'h0, sh1}, 32'h1);
    check("bit0_sh2", {28'h0, sh2}, 32'h0);
    check("bit0_sh3", {28'h0, sh3}, 32'h0);
    cycle();

    // Back-to-back: 16 transfers, one output per cycle once the pipe is primed.
    a_out = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_random_input();
      check("b2b_in_ready", {31'h0, in_ready}, 32'h1);
      cycle();
      if (i >= 1) check("b2b_out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("b2b_count", 32'(n_out - a_out), 32'd16);
    check("b2b_empty", 32'(exp_q.size()), 32'd0);

    // Stall: only two results fit, outputs must hold steady.
    a_in = n_in; a_out = n_out; snap_ok = 1'b0; snap = '0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_random_input();
      cycle();
      if (out_valid) begin
        if (!snap_ok) begin
          snap = {sh3, sh2, sh1};
          snap_ok = 1'b1;
        end else begin
          check("stall_stable", {20'h0, sh3, sh2, sh1}, {20'h0, snap});
        end
      end
    end
    check("stall_accepted", 32'(n_in - a_in), 32'd2);
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    check("stall_out_valid", {31'h0, out_valid}, 32'h1);
    check("stall_occ", {30'h0, dut.occ_q}, 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("stall_drain_count", 32'(n_out - a_out), 32'd2);
    check("stall_drain_empty", 32'(exp_q.size()), 32'd0);

    // Full pipe with simultaneous in/out transfers keeps occupancy at 2.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_random_input();
      cycle();
    end
    a_out = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_random_input();
      cycle();
      check("full_occ", {30'h0, dut.occ_q}, 32'd2);
      check("full_out_valid", {31'h0, out_valid}, 32'h1);
      check("full_in_ready", {31'h0, in_ready}, 32'h1);
    end
    check("full_throughput", 32'(n_out - a_out), 32'd8);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("full_drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full discards everything, including this cycle's transfer.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_random_input();
      cycle();
    end
    rst = 1'b1; out_ready = 1'b1;
    set_random_input();
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_shares", {20'h0, sh3, sh2, sh1}, 32'h0);
    check("mid_rst_occ", {30'h0, dut.occ_q}, 32'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (out_valid) seen++;
    end
    check("mid_rst_no_stale", 32'(seen), 32'd0);

    // Random handshake mix.
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      set_random_input();
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("rand_drain_empty", 32'(exp_q.size()), 32'd0);
    check("rand_final_idle", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/present_ti_compress.md
PRESENT_TI_COMPRESS -- requirements
Module: present_ti_compress

Interface
REQ-001 Parameter REFRESH, default 1: 1 adds fresh-randomness refresh during compression; 0 bypasses refresh, and rnd is ignored.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cf_in  in  36  component-function outputs; bit 9*m+3*(i-1)+(j-1) is the term of coordinate m (0..3), shares i, j (1..3).
REQ-005 in_valid  in  1  cf_in and rnd are valid this cycle.
REQ-006 in_ready  out  1  the block accepts cf_in this cycle.
REQ-007 rnd  in  8  fresh randomness, 2 bits per coordinate m at bits [2m+1:2m].
REQ-008 sh1, sh2, sh3  out  4 each  output shares of the 4-bit S-box result; bit m is coordinate m.
REQ-009 out_valid  out  1  sh1..sh3 hold a valid result.
REQ-010 out_ready  in  1  the downstream side accepts the result this cycle.

Function
REQ-011 Input transfer happens when in_valid and in_ready are both high; output transfer happens when out_valid and out_ready are both high.
REQ-012 Stage 1 registers all 36 cf_in bits, plus rnd, on each input transfer, so no combinational path exists from cf_in to any XOR tree (glitch barrier).
REQ-013 Stage 2 computes raw share s of coordinate m from the stage-1 register as the XOR of bits 9*m+3*(s-1)+0..2, for s = 1..3.
REQ-014 With REFRESH=1, let r0 = rnd[2m] and r1 = rnd[2m+1]; then sh1[m] = raw1 ^ r0, sh2[m] = raw2 ^ r1, sh3[m] = raw3 ^ r0 ^ r1.
REQ-015 Stage 2 outputs are registered, giving a latency of exactly 2 cycles from input transfer to out_valid when there is no stall.
REQ-016 The XOR of sh1, sh2 and sh3 equals the XOR of all 9 cf_in terms of each coordinate, independent of rnd.
REQ-017 The pipeline holds at most 2 results, one per stage; stage s advances when it is empty or the next stage advances this cycle.
REQ-018 in_ready = !stage1_valid | stage2_advance; in_ready is a registered-state function only and never depends combinationally on in_valid.
REQ-019 If out_ready is low while out_valid is high, sh1..sh3 and out_valid hold stable until transfer.
REQ-020 An input transfer and an output transfer in the same cycle with both stages full are allowed: both stages advance and there is no bubble.
REQ-021 Stage-1 state = EMPTY or FULL.
  - EMPTY -> FULL on input transfer.
  - FULL -> EMPTY when stage 1 advances with no new input.
  - FULL -> FULL when it advances and loads a new input in the same cycle.
  - Stage 2 follows the same rule with out_ready.
REQ-022 Data registers load only on their stage's load enable; they never load on a non-transfer cycle, so shares are not recombined by spurious toggles.
REQ-023 A valid counter, 2 bits, reports occupancy 0..2 on an internal signal used by assertions; it never wraps.

Reset
REQ-024 When rst is high at a rising edge, stage-1 and stage-2 valid flags clear to 0, so out_valid = 0 and in_ready = 1 on the next cycle.
REQ-025 Share registers reset to 4'h0, and the occupancy counter resets to 0.
REQ-026 Reset mid-operation discards all in-flight results; a transfer requested in the reset cycle is dropped.

Structure
REQ-027 A shared package holds:
  - constants NUM_COORD=4, NUM_SHARE=3, NUM_CF=36, RND_W=8;
  - a function mapping (m, i, j) to the cf_in index.
REQ-028 One sub-module, ti_compress_bit, performs the 9-to-3 XOR compression with optional refresh for one coordinate; it is instantiated 4 times.

Verification
REQ-029 cf_in = 36'h0 with rnd = 8'hFF, REFRESH=1, single transfer: two cycles later out_valid = 1, and per bit sh1 = 1, sh2 = 1, sh3 = 0, with XOR 0.
REQ-030 cf_in with only bit 0 set and rnd = 0: sh1 = 4'h1, sh2 = 4'h0, sh3 = 4'h0, after 2-cycle latency.
REQ-031 Back-to-back transfers for 16 cycles with out_ready = 1: one output per cycle, in order, and sh1^sh2^sh3 matches the PRESENT S-box reference for random masked inputs.
REQ-032 out_ready held 0 for 5 cycles with in_valid = 1: exactly 2 results are accepted, then in_ready = 0 and outputs stay stable; releasing out_ready drains in order with no loss or duplication.
REQ-033 rst asserted while both stages are full: the next cycle has out_valid = 0, in_ready = 1 and shares = 0; no stale result appears afterwards.
REQ-034 Simultaneous input and output transfer while full: occupancy stays at 2 and throughput is 1 per cycle.
